axil_gpio_arbiter: RTL and testbench
====================================

// Module: axil_gpio_arbiter
// PURPOSE
//   Shares one AXI-lite slave port (the GPIO peripheral) between NUM_M AXI-lite masters.
//   Typical use: CPU data port and a debug/DMA master.
//   Round-robin arbitration, one outstanding transaction at a time.
//   Grant is held from request acceptance through response handshake.
//   Sits between the interconnect master side and the GPIO slave.
// PARAMETERS
//   NUM_M   2   number of masters (>=2); master i uses bit-slice i of every m_* bus
//   ADDR_W  32  address width
//   DATA_W  32  data width; strobe width is DATA_W/8
// PORTS
//   clk                  in   1             clock
//   rst_n                in   1             async active-low reset
//   m_awaddr, m_araddr   in   NUM_M*ADDR_W  per-master write/read address
//   m_wdata              in   NUM_M*DATA_W  per-master write data
//   m_wstrb              in   NUM_M*DATA_W/8 per-master write strobes
//   m_awvalid, m_wvalid  in   NUM_M         per-master write addr/data valid
//   m_arvalid            in   NUM_M         per-master read addr valid
//   m_bready, m_rready   in   NUM_M         per-master response ready
//   m_awready, m_wready  out  NUM_M         per-master write addr/data ready
//   m_arready            out  NUM_M         per-master read addr ready
//   m_bvalid, m_rvalid   out  NUM_M         per-master response valid
//   m_rdata              out  NUM_M*DATA_W  per-master read data (0 when not granted)
//   s_awaddr, s_araddr   out  ADDR_W        slave write/read address
//   s_wdata              out  DATA_W        slave write data
//   s_wstrb              out  DATA_W/8      slave write strobes
//   s_awvalid, s_wvalid, s_arvalid  out 1   slave request valids
//   s_bready, s_rready   out  1             slave response readies
//   s_awready, s_wready, s_arready  in 1    slave request readies
//   s_bvalid, s_rvalid   in   1             slave response valids
//   s_rdata              in   DATA_W        slave read data
//   busy                 out  1             high in any state other than IDLE
//   grant_id             out  $clog2(NUM_M) granted master; holds last grant while IDLE
// BEHAVIOUR
//   FSM: IDLE -> WR_REQ -> WR_RESP -> IDLE  |  IDLE -> RD_REQ -> RD_RESP -> IDLE.
//   Request definitions:
//     wr_req[i] = m_awvalid[i] & m_wvalid[i]
//     rd_req[i] = m_arvalid[i]
//     req[i]    = wr_req[i] | rd_req[i]
//   IDLE:
//     - Search starts at rr_ptr+1, wraps modulo NUM_M; first i with req[i] wins.
//     - Register grant_id=i; go to WR_REQ if wr_req[i], else RD_REQ.
//     - Write wins over read for the same master.
//     - Latency: request seen in cycle N -> slave valid asserted in N+1.
//   WR_REQ:
//     - Drive s_awvalid/s_wvalid from the granted master; s_awvalid = m_awvalid[g] & ~aw_done.
//     - Same rule for W with w_done.
//     - Forward s_awready/s_wready to m_awready[g]/m_wready[g].
//     - aw_done/w_done set on the respective handshake.
//     - Go to WR_RESP once both are done; accept same-cycle handshakes too.
//     - AW and W are driven together, because the GPIO slave samples only when both valids are high.
//   WR_RESP:
//     - m_bvalid[g]=s_bvalid; s_bready=m_bready[g].
//     - On s_bvalid & m_bready[g]: rr_ptr<=g, clear done flags, go to IDLE.
//   RD_REQ:
//     - s_arvalid=m_arvalid[g]; m_arready[g]=s_arready.
//     - On handshake go to RD_RESP.
//   RD_RESP:
//     - m_rvalid[g]=s_rvalid; m_rdata[g]=s_rdata; s_rready=m_rready[g].
//     - On s_rvalid & m_rready[g]: rr_ptr<=g, go to IDLE.
//   Masters other than g:
//     - Every ready/valid/rdata output is 0.
//     - Their requests stay pending; none is dropped or reordered within a master.
//   Slave outputs:
//     - s_* addr/data/strb come from master g in REQ states; 0 otherwise.
//     - All slave valids/readies are 0 in IDLE.
//   At most one transaction is in flight.
//   A new grant is possible in the cycle after the response handshake (1 idle cycle minimum).
//   Reset:
//     - state=IDLE, rr_ptr=NUM_M-1 (master 0 has first priority), grant_id=0, done flags=0.
//     - All outputs 0, busy=0.
//   Reset mid-transaction: the in-flight transaction is abandoned.
//     - No response is delivered.
//     - The slave is reset by the same rst_n.
//   Masters must hold valid until accepted (AXI rule).
//     - If a granted master drops valid before handshake, the grant is still held.
//     - No slave request is issued until valid returns.
// TESTING
//   1. Reset, M0 writes 0x4<-0x0000_A5A5 alone
//      -> s_awvalid in cycle 2; m_bvalid[0] seen; GPIO out=0xA5A5; busy back to 0.
//   2. M0 and M1 both write in the same cycle (0x4<-0x1111 / 0x4<-0x2222)
//      -> M0 served first, then M1; final GPIO out=0x2222; second round has M1 first.
//   3. M1 reads 0x0 with gpio_in=0xBEEF while M0 issues a write
//      -> round-robin order respected; m_rdata[1]=0x0000_BEEF; m_rvalid[0] stays 0.
//   4. Granted master holds m_bready=0 for 5 cycles
//      -> grant held, other requesters stalled, m_*ready of the other master remain 0.
//   5. rst_n asserted during WR_RESP
//      -> immediately busy=0 and all valids 0; the next M1 request is granted after release.
//   6. M0 issues write and read in the same cycle
//      -> write completes first; read is granted afterwards (after M1 if M1 is pending).

Source files
------------

// File: rtl/axil_gpio_arbiter.sv
// -----------------------------------------------------------------------------
// axil_gpio_arbiter
//   Shares one AXI-lite slave port (the GPIO peripheral) between NUM_M
//   AXI-lite masters. Round-robin arbitration, one transaction in flight.
//   The grant is taken in IDLE and held from request acceptance through the
//   response handshake; all other masters see every ready/valid/rdata at 0.
// -----------------------------------------------------------------------------
module axil_gpio_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // master side
  input  logic [NUM_M*ADDR_W-1:0]     m_awaddr,
  input  logic [NUM_M*ADDR_W-1:0]     m_araddr,
  input  logic [NUM_M*DATA_W-1:0]     m_wdata,
  input  logic [NUM_M*DATA_W/8-1:0]   m_wstrb,
  input  logic [NUM_M-1:0]            m_awvalid,
  input  logic [NUM_M-1:0]            m_wvalid,
  input  logic [NUM_M-1:0]            m_arvalid,
  input  logic [NUM_M-1:0]            m_bready,
  input  logic [NUM_M-1:0]            m_rready,
  output logic [NUM_M-1:0]            m_awready,
  output logic [NUM_M-1:0]            m_wready,
  output logic [NUM_M-1:0]            m_arready,
  output logic [NUM_M-1:0]            m_bvalid,
  output logic [NUM_M-1:0]            m_rvalid,
  output logic [NUM_M*DATA_W-1:0]     m_rdata,
  // slave side
  output logic [ADDR_W-1:0]           s_awaddr,
  output logic [ADDR_W-1:0]           s_araddr,
  output logic [DATA_W-1:0]           s_wdata,
  output logic [DATA_W/8-1:0]         s_wstrb,
  output logic                        s_awvalid,
  output logic                        s_wvalid,
  output logic                        s_arvalid,
  output logic                        s_bready,
  output logic                        s_rready,
  input  logic                        s_awready,
  input  logic                        s_wready,
  input  logic                        s_arready,
  input  logic                        s_bvalid,
  input  logic                        s_rvalid,
  input  logic [DATA_W-1:0]           s_rdata,
  // status
  output logic                        busy,
  output logic [$clog2(NUM_M)-1:0]    grant_id
);

  localparam int STRB_W = DATA_W / 8;
  localparam int GW     = $clog2(NUM_M);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t          state;
  logic [GW-1:0]   rr_ptr;
  logic            aw_done;
  logic            w_done;

  // request decode
  logic [NUM_M-1:0] wr_req;
  logic [NUM_M-1:0] rd_req;
  logic [NUM_M-1:0] req;

  assign wr_req = m_awvalid & m_wvalid;
  assign rd_req = m_arvalid;
  assign req    = wr_req | rd_req;

  // arbitration result
  logic          arb_found;
  logic [GW-1:0] arb_idx;
  logic          arb_wr;
  int            arb_cand;

  // granted-master view of the request/response channels
  logic [NUM_M-1:0]  grant_oh;
  logic [ADDR_W-1:0] g_awaddr;
  logic [ADDR_W-1:0] g_araddr;
  logic [DATA_W-1:0] g_wdata;
  logic [STRB_W-1:0] g_wstrb;
  logic              g_awvalid;
  logic              g_wvalid;
  logic              g_arvalid;
  logic              g_bready;
  logic              g_rready;

  // state decodes
  logic st_wr_req;
  logic st_wr_resp;
  logic st_rd_req;
  logic st_rd_resp;
  logic st_req;

  assign st_wr_req  = (state == WR_REQ);
  assign st_wr_resp = (state == WR_RESP);
  assign st_rd_req  = (state == RD_REQ);
  assign st_rd_resp = (state == RD_RESP);
  assign st_req     = st_wr_req | st_rd_req;

  // Round-robin search: start one past the last served master, wrap, first requester wins.
  // NOTE: every variable assigned in an always_comb gets a default at the top;
  // a path that leaves one unassigned would otherwise infer a latch.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_wr    = 1'b0;
    arb_cand  = 0;
    for (int k = 1; k <= NUM_M; k++) begin
      arb_cand = (int'(rr_ptr) + k) % NUM_M;
      for (int j = 0; j < NUM_M; j++) begin
        if (!arb_found && (j == arb_cand) && req[j]) begin
          arb_found = 1'b1;
          arb_idx   = GW'(j);
          arb_wr    = wr_req[j];
        end
      end
    end
  end

  // Select the granted master's request fields and build the one-hot grant.
  always_comb begin
    grant_oh = '0;
    g_awaddr = '0;
    g_araddr = '0;
    g_wdata  = '0;
    g_wstrb  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant_id == GW'(i)) begin
        grant_oh[i] = 1'b1;
        g_awaddr    = m_awaddr[i*ADDR_W +: ADDR_W];
        g_araddr    = m_araddr[i*ADDR_W +: ADDR_W];
        g_wdata     = m_wdata[i*DATA_W +: DATA_W];
        g_wstrb     = m_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  assign g_awvalid = |(m_awvalid & grant_oh);
  assign g_wvalid  = |(m_wvalid  & grant_oh);
  assign g_arvalid = |(m_arvalid & grant_oh);
  assign g_bready  = |(m_bready  & grant_oh);
  assign g_rready  = |(m_rready  & grant_oh);

  // slave request/response handshake qualifiers
  assign s_awvalid = st_wr_req & g_awvalid & ~aw_done;
  assign s_wvalid  = st_wr_req & g_wvalid  & ~w_done;
  assign s_arvalid = st_rd_req & g_arvalid;
  assign s_bready  = st_wr_resp & g_bready;
  assign s_rready  = st_rd_resp & g_rready;

  assign s_awaddr  = st_req ? g_awaddr : '0;
  assign s_araddr  = st_req ? g_araddr : '0;
  assign s_wdata   = st_req ? g_wdata  : '0;
  assign s_wstrb   = st_req ? g_wstrb  : '0;

  // Readies stop once a channel is done so a master's next request is never
  // mistaken for a second handshake of the current one.
  assign m_awready = grant_oh & {NUM_M{st_wr_req  & s_awready & ~aw_done}};
  assign m_wready  = grant_oh & {NUM_M{st_wr_req  & s_wready  & ~w_done}};
  assign m_arready = grant_oh & {NUM_M{st_rd_req  & s_arready}};
  assign m_bvalid  = grant_oh & {NUM_M{st_wr_resp & s_bvalid}};
  assign m_rvalid  = grant_oh & {NUM_M{st_rd_resp & s_rvalid}};

  // Read data reaches only the granted master during the read response.
  always_comb begin
    m_rdata = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant_oh[i] && st_rd_resp) begin
        m_rdata[i*DATA_W +: DATA_W] = s_rdata;
      end
    end
  end

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic b_hs;
  logic r_hs;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid  & s_wready;
  assign ar_hs = s_arvalid & s_arready;
  assign b_hs  = st_wr_resp & s_bvalid & g_bready;
  assign r_hs  = st_rd_resp & s_rvalid & g_rready;

  // Transaction FSM: grant in IDLE, hold it through request and response.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= GW'(NUM_M - 1);
      grant_id <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant_id <= arb_idx;
            busy     <= 1'b1;
            state    <= arb_wr ? WR_REQ : RD_REQ;
          end
        end
        WR_REQ: begin
          aw_done <= aw_done | aw_hs;
          w_done  <= w_done  | w_hs;
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            rr_ptr  <= grant_id;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        RD_REQ: begin
          if (ar_hs) begin
            state <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (r_hs) begin
            rr_ptr <= grant_id;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_gpio_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axil_gpio_arbiter
//   Two AXI-lite master drivers, a small GPIO slave model (0x0 reads gpio_in,
//   0x4 is the strobed output register) and a response scoreboard. A vector
//   table covers single transactions; hand-written sequences cover contention,
//   held responses, reset mid-transaction and write/read from one master.
// -----------------------------------------------------------------------------
module tb_axil_gpio_arbiter;

  localparam int NUM_M   = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = DATA_W / 8;
  localparam int TIMEOUT = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // per-master driver state
  logic [NUM_M-1:0]  awv = '0, wv = '0, arv = '0, brdy = '0, rrdy = '0;
  logic [ADDR_W-1:0] awaddr_t [NUM_M];
  logic [ADDR_W-1:0] araddr_t [NUM_M];
  logic [DATA_W-1:0] wdata_t  [NUM_M];
  logic [STRB_W-1:0] wstrb_t  [NUM_M];

  logic [NUM_M*ADDR_W-1:0] m_awaddr, m_araddr;
  logic [NUM_M*DATA_W-1:0] m_wdata, m_rdata;
  logic [NUM_M*STRB_W-1:0] m_wstrb;
  logic [NUM_M-1:0] m_awready, m_wready, m_arready, m_bvalid, m_rvalid;

  assign m_awaddr = {awaddr_t[1], awaddr_t[0]};
  assign m_araddr = {araddr_t[1], araddr_t[0]};
  assign m_wdata  = {wdata_t[1], wdata_t[0]};
  assign m_wstrb  = {wstrb_t[1], wstrb_t[0]};

  logic [ADDR_W-1:0] s_awaddr, s_araddr;
  logic [DATA_W-1:0] s_wdata, s_rdata;
  logic [STRB_W-1:0] s_wstrb;
  logic s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready;
  logic s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic busy;
  logic [0:0] grant_id;

  axil_gpio_arbiter #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_awaddr(m_awaddr), .m_araddr(m_araddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_awvalid(awv), .m_wvalid(wv), .m_arvalid(arv), .m_bready(brdy), .m_rready(rrdy),
    .m_awready(m_awready), .m_wready(m_wready), .m_arready(m_arready),
    .m_bvalid(m_bvalid), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .s_awaddr(s_awaddr), .s_araddr(s_araddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_awvalid(s_awvalid), .s_wvalid(s_wvalid), .s_arvalid(s_arvalid),
    .s_bready(s_bready), .s_rready(s_rready),
    .s_awready(s_awready), .s_wready(s_wready), .s_arready(s_arready),
    .s_bvalid(s_bvalid), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  // ---------------- GPIO slave model ----------------
  logic [DATA_W-1:0] gpio_out;
  logic [DATA_W-1:0] gpio_in = '0;
  logic sl_bvalid, sl_rvalid;
  logic [DATA_W-1:0] sl_rdata;

  // accepts a write only when both AW and W are valid
  assign s_awready = s_awvalid & s_wvalid & ~sl_bvalid;
  assign s_wready  = s_awready;
  assign s_arready = s_arvalid & ~sl_rvalid;
  assign s_bvalid  = sl_bvalid;
  assign s_rvalid  = sl_rvalid;
  assign s_rdata   = sl_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out  <= '0;
      sl_bvalid <= 1'b0;
      sl_rvalid <= 1'b0;
      sl_rdata  <= '0;
    end else begin
      if (s_awvalid && s_awready) begin
        if (s_awaddr == 32'h4)
          for (int b = 0; b < STRB_W; b++)
            if (s_wstrb[b]) gpio_out[b*8 +: 8] <= s_wdata[b*8 +: 8];
        sl_bvalid <= 1'b1;
      end else if (sl_bvalid && s_bready) begin
        sl_bvalid <= 1'b0;
      end
      if (s_arvalid && s_arready) begin
        sl_rdata  <= (s_araddr == 32'h0) ? gpio_in : (s_araddr == 32'h4) ? gpio_out : '0;
        sl_rvalid <= 1'b1;
      end else if (sl_rvalid && s_rready) begin
        sl_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          m;
    bit          wr;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  task automatic push_exp(input int m, input bit wr, input logic [31:0] d);
    exp_t e;
    e.m = m; e.wr = wr; e.rdata = d;
    sb.push_back(e);
  endtask

  task automatic got_resp(input int m, input bit wr, input logic [31:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_resp: got master %0d wr %0d with nothing expected", m, wr);
    end else begin
      e = sb.pop_front();
      check("resp_master", m, e.m);
      check("resp_kind", {31'b0, wr}, {31'b0, e.wr});
      if (!wr) check("resp_rdata", d, e.rdata);
    end
  endtask

  bit rv0_seen = 1'b0;

  // Response monitor and per-cycle isolation check, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      logic iso_ok;
      iso_ok = 1'b1;
      if (m_rvalid[0]) rv0_seen = 1'b1;
      for (int i = 0; i < NUM_M; i++) begin
        if (m_bvalid[i] && brdy[i]) got_resp(i, 1'b1, '0);
        if (m_rvalid[i] && rrdy[i]) got_resp(i, 1'b0, m_rdata[i*DATA_W +: DATA_W]);
        if ((!busy || i != int'(grant_id)) &&
            (m_awready[i] || m_wready[i] || m_arready[i] || m_bvalid[i] || m_rvalid[i] ||
             m_rdata[i*DATA_W +: DATA_W] != '0))
          iso_ok = 1'b0;
      end
      if (!busy && (s_awvalid || s_wvalid || s_arvalid || s_bready || s_rready))
        iso_ok = 1'b0;
      check("isolation", {31'b0, iso_ok}, 32'd1);
    end
  end

  // ---------------- master driver ----------------
  task automatic abort_master(input int i);
    awv[i] = 1'b0; wv[i] = 1'b0; arv[i] = 1'b0; brdy[i] = 1'b0; rrdy[i] = 1'b0;
  endtask

  task automatic do_txn(input int i, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input int bhold);
    bit a_ok, w_ok, sa, sw;
    int n;
    a_ok = 1'b0;
    w_ok = !wr;
    if (wr) begin
      awaddr_t[i] = addr; wdata_t[i] = data; wstrb_t[i] = strb;
      awv[i] = 1'b1; wv[i] = 1'b1;
    end else begin
      araddr_t[i] = addr; arv[i] = 1'b1;
    end
    n = 0;
    while (!(a_ok && w_ok)) begin
      @(negedge clk);
      if (!rst_n) begin abort_master(i); return; end
      sa = wr ? (awv[i] && m_awready[i]) : (arv[i] && m_arready[i]);
      sw = wr && wv[i] && m_wready[i];
      @(posedge clk); #1;
      if (!rst_n) begin abort_master(i); return; end
      if (sa) begin a_ok = 1'b1; if (wr) awv[i] = 1'b0; else arv[i] = 1'b0; end
      if (sw) begin w_ok = 1'b1; wv[i] = 1'b0; end
      n++;
      if (n > TIMEOUT) begin
        check("accept_timeout", 32'(n), 32'(TIMEOUT));
        abort_master(i);
        return;
      end
    end
    repeat (bhold) begin
      @(posedge clk); #1;
      if (!rst_n) begin abort_master(i); return; end
    end
    if (wr) brdy[i] = 1'b1; else rrdy[i] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin abort_master(i); return; end
      if (wr ? m_bvalid[i] : m_rvalid[i]) break;
      n++;
      if (n > TIMEOUT) begin
        check("resp_timeout", 32'(n), 32'(TIMEOUT));
        abort_master(i);
        return;
      end
    end
    @(posedge clk); #1;
    brdy[i] = 1'b0; rrdy[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      abort_master(i);
      awaddr_t[i] = '0; araddr_t[i] = '0; wdata_t[i] = '0; wstrb_t[i] = '0;
    end
    sb.delete();
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_grant", {31'b0, grant_id}, 32'd0);
    check("rst_m_out", {22'b0, m_awready, m_wready, m_arready, m_bvalid, m_rvalid},
          32'd0);
    check("rst_s_out", {27'b0, s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}, 32'd0);
    check("rst_data", {31'b0, |{m_rdata, s_awaddr, s_araddr, s_wdata, s_wstrb}}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic end_test(input string name);
    repeat (2) @(negedge clk);
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          m;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] gin;
    logic [31:0] exp_rdata;
    logic [31:0] exp_gpio;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 1'b1, 32'h4, 32'h1234_5678, 4'hF, 32'h0,         32'h0,         32'h1234_5678};
    tbl[1] = '{1, 1'b0, 32'h4, 32'h0,         4'h0, 32'h0,         32'h1234_5678, 32'h1234_5678};
    tbl[2] = '{1, 1'b1, 32'h4, 32'hCAFE_F00D, 4'hF, 32'h0,         32'h0,         32'hCAFE_F00D};
    tbl[3] = '{0, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'h1, 32'h0,         32'h0,         32'hCAFE_F0FF};
    tbl[4] = '{0, 1'b0, 32'h4, 32'h0,         4'h0, 32'h0,         32'hCAFE_F0FF, 32'hCAFE_F0FF};
    tbl[5] = '{1, 1'b0, 32'h0, 32'h0,         4'h0, 32'h5A5A_0000, 32'h5A5A_0000, 32'hCAFE_F0FF};
    tbl[6] = '{0, 1'b0, 32'h8, 32'h0,         4'h0, 32'h0,         32'h0,         32'hCAFE_F0FF};

    // 1: single write, slave valid one cycle after the request
    do_reset();
    push_exp(0, 1'b1, '0);
    fork
      do_txn(0, 1'b1, 32'h4, 32'h0000_A5A5, 4'hF, 0);
      begin
        @(negedge clk);
        check("t1_awvalid_n", {31'b0, s_awvalid}, 32'd0);
        @(negedge clk);
        check("t1_awvalid_n1", {31'b0, s_awvalid}, 32'd1);
        check("t1_wvalid", {31'b0, s_wvalid}, 32'd1);
        check("t1_awaddr", s_awaddr, 32'h4);
        check("t1_wdata", s_wdata, 32'h0000_A5A5);
      end
    join
    check("t1_gpio", gpio_out, 32'h0000_A5A5);
    @(negedge clk);
    check("t1_busy", {31'b0, busy}, 32'd0);
    end_test("t1");

    // table: single transactions in sequence
    do_reset();
    for (int v = 0; v < 7; v++) begin
      gpio_in = tbl[v].gin;
      push_exp(tbl[v].m, tbl[v].wr, tbl[v].exp_rdata);
      do_txn(tbl[v].m, tbl[v].wr, tbl[v].addr, tbl[v].wdata, tbl[v].strb, 0);
      @(negedge clk);
      check("tbl_gpio", gpio_out, tbl[v].exp_gpio);
      check("tbl_grant_hold", {31'b0, grant_id}, 32'(tbl[v].m));
    end
    end_test("tbl");

    // 2: simultaneous writes, M0 first; M0 re-requests and M1 goes ahead of it
    do_reset();
    push_exp(0, 1'b1, '0);
    push_exp(1, 1'b1, '0);
    push_exp(0, 1'b1, '0);
    fork
      begin
        do_txn(0, 1'b1, 32'h4, 32'h0000_1111, 4'hF, 0);
        do_txn(0, 1'b1, 32'h4, 32'h0000_3333, 4'hF, 0);
      end
      begin
        do_txn(1, 1'b1, 32'h4, 32'h0000_2222, 4'hF, 0);
        check("t2_gpio_after_m1", gpio_out, 32'h0000_2222);
      end
    join
    check("t2_gpio_final", gpio_out, 32'h0000_3333);
    end_test("t2");

    // 3: M1 reads gpio_in while M0 writes
    do_reset();
    gpio_in  = 32'h0000_BEEF;
    rv0_seen = 1'b0;
    push_exp(0, 1'b1, '0);
    push_exp(1, 1'b0, 32'h0000_BEEF);
    fork
      do_txn(0, 1'b1, 32'h4, 32'h0000_0077, 4'hF, 0);
      do_txn(1, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    join
    check("t3_rvalid0", {31'b0, rv0_seen}, 32'd0);
    end_test("t3");

    // 4: granted master holds bready low for 5 cycles
    do_reset();
    push_exp(0, 1'b1, '0);
    push_exp(1, 1'b1, '0);
    fork
      do_txn(0, 1'b1, 32'h4, 32'h0000_AAAA, 4'hF, 5);
      do_txn(1, 1'b1, 32'h4, 32'h0000_BBBB, 4'hF, 0);
      begin
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_bvalid[0] && n < 50);
        check("t4_bvalid_seen", {31'b0, m_bvalid[0]}, 32'd1);
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          check("t4_hold_grant", {31'b0, grant_id}, 32'd0);
          check("t4_hold_m1", {29'b0, m_awready[1], m_wready[1], m_bvalid[1]}, 32'd0);
          check("t4_hold_bvalid", {31'b0, m_bvalid[0]}, 32'd1);
        end
      end
    join
    check("t4_gpio", gpio_out, 32'h0000_BBBB);
    end_test("t4");

    // 5: reset asserted in WR_RESP abandons the write
    do_reset();
    push_exp(0, 1'b1, '0);
    fork
      do_txn(0, 1'b1, 32'h4, 32'h0000_DEAD, 4'hF, 40);
      begin
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_bvalid[0] && n < 50);
        check("t5_bvalid_seen", {31'b0, m_bvalid[0]}, 32'd1);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("t5_busy", {31'b0, busy}, 32'd0);
        check("t5_valids", {29'b0, |m_bvalid, |m_rvalid, s_bready}, 32'd0);
      end
    join
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push_exp(1, 1'b1, '0);
    fork
      do_txn(1, 1'b1, 32'h4, 32'h0000_1234, 4'hF, 0);
      begin
        repeat (2) @(negedge clk);
        check("t5_grant_m1", {31'b0, grant_id}, 32'd1);
        check("t5_busy_m1", {31'b0, busy}, 32'd1);
      end
    join
    check("t5_gpio", gpio_out, 32'h0000_1234);
    end_test("t5");

    // 6: M0 write+read together with M1 write pending
    do_reset();
    gpio_in     = 32'h0000_0F0F;
    araddr_t[0] = 32'h0;
    arv[0]      = 1'b1;
    push_exp(0, 1'b1, '0);
    push_exp(1, 1'b1, '0);
    push_exp(0, 1'b0, 32'h0000_0F0F);
    fork
      begin
        do_txn(0, 1'b1, 32'h4, 32'h0000_C0DE, 4'hF, 0);
        do_txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
      end
      do_txn(1, 1'b1, 32'h4, 32'h0000_F00D, 4'hF, 0);
    join
    check("t6_gpio", gpio_out, 32'h0000_F00D);
    end_test("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
